// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch front end:
//   - opcode encodings carried in instr[31:29]
//   - fsm_state_t, the fetch controller state encoding
//   - decode(), the combinational opcode -> control decoder
// Optional feature macro: FETCH_HALT_EN (opcode 7 becomes HALT; otherwise NOP).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_STORE = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_RSVD  = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic is_jmp;
    logic is_halt;
  } decode_t;

  // Each opcode sets at most one of reg_write / mem_write, so the two can
  // never be asserted together.
  function automatic decode_t decode(input logic [OPCODE_W-1:0] opcode);
    decode_t d;
    d = '0;
    case (opcode)
      OP_ADD,
      OP_LOAD,
      OP_ADDI:  d.reg_write = 1'b1;
      OP_STORE: d.mem_write = 1'b1;
      OP_JMP:   d.is_jmp    = 1'b1;
`ifdef FETCH_HALT_EN
      OP_HALT:  d.is_halt   = 1'b1;
`endif
      // OP_NOP, OP_RSVD and (without the halt feature) OP_HALT decode to NOP.
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage : cpu_pkg

// File: rtl/imem_rom.sv
// -----------------------------------------------------------------------------
// imem_rom
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are never cleared by reset, so a program survives a reset.
// Ports:
//   clk    in   clock; writes take effect on its rising edge
//   we     in   write enable
//   waddr  in   [AW-1:0] write address
//   wdata  in   [31:0]   write data
//   raddr  in   [AW-1:0] read address
//   rdata  out  [31:0]   word at raddr (combinational)
// -----------------------------------------------------------------------------
module imem_rom #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset branch on purpose; a memory with a
  // reset cannot map onto RAM/LUT-RAM and the program must survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : imem_rom

// File: rtl/fetch_control.sv
// -----------------------------------------------------------------------------
// fetch_control
// Instruction fetch/decode front end. Runs from address 0 after a start pulse,
// reads the instruction memory combinationally at PC and presents one decoded
// instruction per cycle through a valid/ready output register.
// Optional feature macro: FETCH_HALT_EN -- opcode 7 stops the fetch; once the
// HALT word is consumed the controller parks in HALT until the next start.
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   asynchronous reset, active low
//   start       in   one-cycle pulse: (re)start at address 0 from IDLE/HALT
//   imem_we     in   instruction memory write enable (ignored while running)
//   imem_waddr  in   [AW-1:0] instruction memory write address
//   imem_wdata  in   [31:0]   instruction memory write data
//   out_ready   in   downstream accepts the current output
//   out_valid   out  instr_a/reg_write/mem_write/pc_out are valid
//   instr_a     out  [2:0] opcode field instr[31:29]
//   reg_write   out  decoded register-file write enable
//   mem_write   out  decoded data-memory write enable
//   pc_out      out  [AW-1:0] address of the presented instruction
//   halted      out  high while in HALT
// -----------------------------------------------------------------------------
module fetch_control
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [2:0]    instr_a,
  output logic          reg_write,
  output logic          mem_write,
  output logic [AW-1:0] pc_out,
  output logic          halted
);

  fsm_state_t    state, state_next;
  logic [AW-1:0] pc, pc_next;
  logic [31:0]   instr;
  decode_t       dec;
  logic          load;
  logic          out_halt;   // the output register currently holds a HALT word
  logic          imem_wr_en;

  // The program may only be changed while nothing is being fetched.
  assign imem_wr_en = imem_we && (state != ST_RUN);

  imem_rom #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (imem_wr_en),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc),
    .rdata (instr)
  );

  assign dec = decode(instr[31:29]);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    case (state)
      ST_IDLE,
      ST_HALT: begin
        // Entering RUN leaves the output register empty; the first fetch
        // happens one cycle later, so a word written together with start is
        // already in memory when it is read.
        if (start) begin
          state_next = ST_RUN;
          pc_next    = '0;
        end
      end
      ST_RUN: begin
        // Nothing is fetched past a HALT word sitting in the output register.
        load = (!out_valid || out_ready) && !out_halt;
        if (load) begin
          // JMP redirects the very next fetch, so no bubble is inserted.
          pc_next = dec.is_jmp ? instr[AW-1:0] : pc + AW'(1);
        end
`ifdef FETCH_HALT_EN
        if (out_halt && out_valid && out_ready) begin
          state_next = ST_HALT;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      instr_a   <= '0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      pc_out    <= '0;
      out_halt  <= 1'b0;
    end else if ((state != ST_RUN) && start) begin
      out_valid <= 1'b0;
      out_halt  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      instr_a   <= instr[31:29];
      reg_write <= dec.reg_write;
      mem_write <= dec.mem_write;
      pc_out    <= pc;
      out_halt  <= dec.is_halt;
    end else if (out_valid && out_ready) begin
      // Consumed with nothing new behind it (only after a HALT word).
      out_valid <= 1'b0;
      out_halt  <= 1'b0;
    end
  end

`ifdef FETCH_HALT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule : fetch_control

// File: tb/tb_fetch_control.sv
// -----------------------------------------------------------------------------
// tb_fetch_control
// Directed bench for fetch_control (IMEM_DEPTH = 16). Builds with or without
// FETCH_HALT_EN; the opcode-7 expectations and the HALT section follow it.
// -----------------------------------------------------------------------------
module tb_fetch_control;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          out_ready;
  logic          out_valid;
  logic [2:0]    instr_a;
  logic          reg_write;
  logic          mem_write;
  logic [AW-1:0] pc_out;
  logic          halted;

  int checks = 0;
  int errors = 0;

  fetch_control #(
    .IMEM_DEPTH (DEPTH),
    .AW         (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .instr_a    (instr_a),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .pc_out     (pc_out),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [2:0] op, input int target);
    logic [28:0] t;
    t = 29'(target);
    return {op, t};
  endfunction

  // {out_valid, instr_a, reg_write, mem_write, pc_out}
  function automatic logic [9:0] vec(input logic v, input logic [2:0] a,
                                     input logic rw, input logic mw,
                                     input int pc);
    logic [AW-1:0] p;
    p = AW'(pc);
    return {v, a, rw, mw, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [9:0] exp);
    check(tag, 32'({out_valid, instr_a, reg_write, mem_write, pc_out}), 32'(exp));
  endtask

  task automatic imem_write(input int addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = AW'(addr);
    imem_wdata = data;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    out_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    check_out("reset_outputs", vec(0, 0, 0, 0, 0));
    check("reset_halted", 32'(halted), 32'(0));

    // Program: ADD, STORE, LOAD, ADDI, NOPs, opcode 7 at 10
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      imem_write(i, ins(3'd0, i));
    end
    imem_write(0, ins(3'd1, 0));
    imem_write(1, ins(3'd2, 0));
    imem_write(2, ins(3'd3, 0));
    imem_write(3, ins(3'd4, 0));
    imem_write(10, ins(3'd7, 0));

    // Basic decode stream, ready held high
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check_out("start_empty", vec(0, 0, 0, 0, 0));
    tick(); check_out("add_pc0",   vec(1, 1, 1, 0, 0));
    tick(); check_out("store_pc1", vec(1, 2, 0, 1, 1));
    tick(); check_out("load_pc2",  vec(1, 3, 1, 0, 2));
    tick(); check_out("addi_pc3",  vec(1, 4, 1, 0, 3));
    tick(); check_out("nop_pc4",   vec(1, 0, 0, 0, 4));

    // Reset mid-RUN clears outputs without a clock edge
    rst = 1'b0;
    #1;
    check_out("async_reset_outputs", vec(0, 0, 0, 0, 0));
    check("async_reset_halted", 32'(halted), 32'(0));
    rst   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); check_out("rerun_pc0", vec(1, 1, 1, 0, 0));
    tick(); check_out("rerun_pc1", vec(1, 2, 0, 1, 1));
    tick(); check_out("rerun_pc2", vec(1, 3, 1, 0, 2));

    // Jumps: 1 -> 2 and 3 -> 8, write and start during RUN ignored
    pulse_reset();
    imem_write(1, ins(3'd5, 2));
    imem_write(3, ins(3'd5, 8));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); check_out("jmp_pc0", vec(1, 1, 1, 0, 0));
    imem_we    = 1'b1;
    imem_waddr = 4'd9;
    imem_wdata = ins(3'd2, 0);
    tick(); check_out("jmp_pc1", vec(1, 5, 0, 0, 1));
    imem_we = 1'b0;
    start   = 1'b1;
    tick(); check_out("jmp_pc2_start_ignored", vec(1, 3, 1, 0, 2));
    start   = 1'b0;
    tick(); check_out("jmp_pc3", vec(1, 5, 0, 0, 3));
    tick(); check_out("jmp_target_pc8", vec(1, 0, 0, 0, 8));
    tick(); check_out("run_write_dropped_pc9", vec(1, 0, 0, 0, 9));

    // Back-pressure: three stalled cycles hold everything
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_out("stall_hold_pc9", vec(1, 0, 0, 0, 9));
    end
    out_ready = 1'b1;
    tick(); check_out("after_stall_pc10_op7", vec(1, 7, 0, 0, 10));
    tick();
`ifdef FETCH_HALT_EN
    check_out("op7_halts_no_load", vec(0, 7, 0, 0, 10));
    check("op7_halted", 32'(halted), 32'(1));
`else
    check_out("op7_is_nop_pc11", vec(1, 0, 0, 0, 11));
    check("op7_not_halted", 32'(halted), 32'(0));
`endif

    // Write together with start, reserved opcode, PC wrap 15 -> 0
    pulse_reset();
    imem_write(14, ins(3'd6, 0));
    imem_write(15, ins(3'd4, 0));
    imem_we    = 1'b1;
    imem_waddr = 4'd0;
    imem_wdata = ins(3'd5, 14);
    start      = 1'b1;
    tick();
    imem_we    = 1'b0;
    start      = 1'b0;
    tick(); check_out("same_cycle_write_pc0", vec(1, 5, 0, 0, 0));
    tick(); check_out("reserved_pc14", vec(1, 6, 0, 0, 14));
    tick(); check_out("addi_pc15", vec(1, 4, 1, 0, 15));
    tick(); check_out("wrap_pc0", vec(1, 5, 0, 0, 0));
    tick(); check_out("wrap_pc14", vec(1, 6, 0, 0, 14));

`ifdef FETCH_HALT_EN
    // HALT at 2: emits 0,1,2 then parks; restart from HALT
    pulse_reset();
    imem_write(0, ins(3'd1, 0));
    imem_write(2, ins(3'd7, 0));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); check_out("h_pc0", vec(1, 1, 1, 0, 0));
    check("h_running_not_halted", 32'(halted), 32'(0));
    imem_we    = 1'b1;
    imem_waddr = 4'd2;
    imem_wdata = ins(3'd1, 0);
    tick(); check_out("h_pc1", vec(1, 5, 0, 0, 1));
    imem_we = 1'b0;
    tick(); check_out("h_pc2_halt", vec(1, 7, 0, 0, 2));
    tick(); check("h_out_valid_low", 32'(out_valid), 32'(0));
    check("h_halted", 32'(halted), 32'(1));
    tick(); check("h_stays_halted", 32'(halted), 32'(1));
    check("h_stays_invalid", 32'(out_valid), 32'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("h_restart_not_halted", 32'(halted), 32'(0));
    tick(); check_out("h_restart_pc0", vec(1, 1, 1, 0, 0));
    tick(); check_out("h_restart_pc1", vec(1, 5, 0, 0, 1));
    tick(); check_out("h_write_dropped_pc2", vec(1, 7, 0, 0, 2));
    tick(); check("h_halted_again", 32'(halted), 32'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_control

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 16, meaning the number of 32-bit instruction words (power of two, 2..256).
REQ-002 SHALL have parameter AW, default $clog2(IMEM_DEPTH), meaning the PC/address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 start  input  1  one-cycle pulse that begins execution at address 0.
REQ-006 imem_we  input  1  instruction memory write enable.
REQ-007 imem_waddr  input  AW  instruction memory write address.
REQ-008 imem_wdata  input  32  instruction memory write data.
REQ-009 out_ready  input  1  downstream datapath accepts the current output.
REQ-010 out_valid  output  1  instr_a/reg_write/mem_write/pc_out are valid.
REQ-011 instr_a  output  3  opcode field instr[31:29], fed to the datapath instruction_A input.
REQ-012 reg_write  output  1  decoded register-file write enable.
REQ-013 mem_write  output  1  decoded data-memory write enable.
REQ-014 pc_out  output  AW  address of the instruction currently presented.
REQ-015 halted  output  1  high while in HALT.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and HALT.
REQ-017 SHALL accept imem_we writes only in IDLE or HALT; writes in RUN are dropped.
REQ-018 SHALL enter RUN on start in IDLE or HALT, with PC = 0 and the output register empty; start in RUN is ignored.
REQ-019 SHALL read IMEM combinationally at PC.
REQ-020 SHALL use a load condition of out_valid==0 or out_ready==1; on load, the output register captures imem[PC], pc_out<=PC, and out_valid<=1.
REQ-021 SHALL hold all outputs and PC stable while out_valid && !out_ready.
REQ-022 SHALL decode: opcode 0 NOP (0,0); 1 ADD (rw=1); 2 STORE (mw=1); 3 LOAD (rw=1); 4 ADDI (rw=1); 5 JMP (0,0); 6 reserved = NOP.
REQ-023 SHALL never assert reg_write and mem_write together.
REQ-024 SHALL compute the next PC on load as PC+1 modulo IMEM_DEPTH (wraps from IMEM_DEPTH-1 to 0), except for JMP, where next PC = instr[AW-1:0] with no bubble.
REQ-025 SHALL give first out_valid one cycle after start; in RUN with out_ready held high, one instruction is emitted per cycle.
REQ-026 SHALL clear out_valid when an output is consumed and no further load occurs.
REQ-027 SHALL, if start and imem_we occur in the same cycle in IDLE, perform the write and begin execution; the fetch sees the new word.

Reset
REQ-028 SHALL, while rst=0, set state to IDLE, PC to 0, out_valid, instr_a, reg_write, mem_write, pc_out and halted to 0.
REQ-029 SHALL abort a reset asserted mid-RUN immediately, with no partial output.
REQ-030 SHALL NOT reset IMEM contents.

Configuration
REQ-031 SHALL, with FETCH_HALT_EN defined, treat opcode 7 as HALT: it is emitted as (instr_a=7, 0, 0), no further load occurs, and the FSM enters HALT once it is consumed.
REQ-032 SHALL, in HALT, keep halted=1 and out_valid=0.
REQ-033 SHALL, without FETCH_HALT_EN, treat opcode 7 as NOP, keep halted constant 0 and never enter HALT.

Structure
REQ-034 SHALL place opcode localparams (OP_NOP..OP_HALT) and an fsm_state_t enum in shared package cpu_pkg.
REQ-035 SHALL implement IMEM as a sub-module imem_rom: synchronous write port, asynchronous read, no reset.
REQ-036 SHALL implement decode as a combinational function in cpu_pkg.

Verification
REQ-037 Load ADD, STORE, LOAD, ADDI at 0..3, pulse start, ready=1 -> four valid cycles: (1,1,0), (2,0,1), (3,1,0), (4,1,0), pc_out 0..3.
REQ-038 JMP to 2 at address 1, ready=1 -> pc_out sequence 0,1,2,3 with no gap in out_valid.
REQ-039 out_ready=0 for 3 cycles mid-stream -> outputs frozen, no instruction lost or duplicated.
REQ-040 Write to address 15 of a 16-word IMEM, run to wrap -> pc_out 15 then 0.
REQ-041 FETCH_HALT_EN on, HALT at 2 -> emits 0,1,2, then halted=1 and out_valid=0; start restarts at 0; a write during RUN is ignored.
REQ-042 rst=0 asserted mid-RUN -> all outputs 0 immediately; IMEM retained; start reproduces the identical sequence.
